// File: rtl/iir_biquad_cascade.sv
// NSEC cascaded direct-form-I biquads time-sharing one multiply-accumulate.
// Optional IIR_TAP_OUT_EN adds per-section outputs on y_tap.
module iir_biquad_cascade #(
  parameter int DW   = 21,
  parameter int CW   = 18,
  parameter int FRAC = 14,
  parameter int NSEC = 3,
  parameter int AW   = $clog2(5*NSEC)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] x,
  output logic [DW-1:0] y,
  output logic          y_valid,
  output logic          busy,
  output logic          sat,
  output logic          overrun,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [CW-1:0] coef_data,
  output logic          coef_err
`ifdef IIR_TAP_OUT_EN
  ,
  output logic [NSEC*DW-1:0] y_tap
`endif
);

  localparam int ACW = DW + CW + 3;
  localparam int PW  = DW + CW;
  localparam int NCO = 5 * NSEC;
  localparam int SW  = (NSEC > 1) ? $clog2(NSEC) : 1;

  localparam logic [AW-1:0] NCO_A = AW'(NCO);
  localparam logic [SW-1:0] LAST  = SW'(NSEC - 1);

  localparam logic signed [ACW-1:0] RND =
    ACW'(2 ** (FRAC - 1));
  localparam logic signed [ACW-1:0] YMAX =
    {{(ACW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACW-1:0] YMIN =
    {{(ACW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, WB} state_t;
  state_t state, state_nxt;

  logic [2:0]    tap;
  logic [SW-1:0] sec;
  logic [AW-1:0] csel;

  logic signed [DW-1:0] xin;
  logic signed [DW-1:0] x1 [NSEC];
  logic signed [DW-1:0] x2 [NSEC];
  logic signed [DW-1:0] y1 [NSEC];
  logic signed [DW-1:0] y2 [NSEC];
  logic signed [CW-1:0] coef [NCO];

  logic signed [CW-1:0]  cval;
  logic signed [DW-1:0]  opd;
  logic signed [PW-1:0]  prod;
  logic signed [ACW-1:0] prod_x;
  logic signed [ACW-1:0] acc;
  logic signed [ACW-1:0] acc_nxt;
  logic signed [ACW-1:0] rnd;
  logic signed [ACW-1:0] rsh;
  logic signed [DW-1:0]  rsat;

  logic clip;
  logic sat_acc;
  logic accept;
  logic wr_ok;
  logic last;

  assign last   = (sec == LAST);
  assign accept = (state == IDLE) && en && !clr;
  assign wr_ok  = coef_we && (state == IDLE) && !accept &&
                  (coef_addr < NCO_A);
  assign csel   = AW'(5 * int'(sec) + int'(tap));

  always_comb begin
    cval = coef[csel];
    opd  = xin;
    case (tap)
      3'd1:    opd = x1[sec];
      3'd2:    opd = x2[sec];
      3'd3:    opd = y1[sec];
      3'd4:    opd = y2[sec];
      default: opd = xin;
    endcase
  end

  assign prod   = PW'(cval) * PW'(opd);
  assign prod_x = ACW'(prod);

  // Feedback taps (a1, a2) are subtracted.
  always_comb begin
    acc_nxt = acc + prod_x;
    if (tap == 3'd0)
      acc_nxt = prod_x;
    else if (tap >= 3'd3)
      acc_nxt = acc - prod_x;
  end

  assign rnd = acc + RND;
  assign rsh = rnd >>> FRAC;

  always_comb begin
    clip = 1'b0;
    rsat = rsh[DW-1:0];
    if (rsh > YMAX) begin
      clip = 1'b1;
      rsat = YMAX[DW-1:0];
    end else if (rsh < YMIN) begin
      clip = 1'b1;
      rsat = YMIN[DW-1:0];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = MAC;
      MAC:  if (tap == 3'd4) state_nxt = WB;
      WB:   state_nxt = last ? IDLE : MAC;
      default: state_nxt = IDLE;
    endcase
    if (clr)
      state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tap      <= '0;
      sec      <= '0;
      xin      <= '0;
      acc      <= '0;
      y        <= '0;
      y_valid  <= 1'b0;
      busy     <= 1'b0;
      sat      <= 1'b0;
      sat_acc  <= 1'b0;
      overrun  <= 1'b0;
      coef_err <= 1'b0;
      for (int i = 0; i < NSEC; i++) begin
        x1[i] <= '0;
        x2[i] <= '0;
        y1[i] <= '0;
        y2[i] <= '0;
      end
`ifdef IIR_TAP_OUT_EN
      y_tap <= '0;
`endif
    end else begin
      y_valid  <= 1'b0;
      coef_err <= coef_we && !wr_ok;
      if (clr) begin
        tap     <= '0;
        sec     <= '0;
        busy    <= 1'b0;
        sat_acc <= 1'b0;
        overrun <= 1'b0;
        for (int i = 0; i < NSEC; i++) begin
          x1[i] <= '0;
          x2[i] <= '0;
          y1[i] <= '0;
          y2[i] <= '0;
        end
      end else begin
        if (en && state != IDLE)
          overrun <= 1'b1;
        case (state)
          IDLE: begin
            busy <= accept;
            if (accept) begin
              xin     <= x;
              tap     <= '0;
              sec     <= '0;
              sat_acc <= 1'b0;
            end
          end
          MAC: begin
            acc <= acc_nxt;
            tap <= (tap == 3'd4) ? 3'd0 : tap + 3'd1;
          end
          WB: begin
            x2[sec] <= x1[sec];
            x1[sec] <= xin;
            y2[sec] <= y1[sec];
            y1[sec] <= rsat;
            xin     <= rsat;
            tap     <= '0;
            sat_acc <= sat_acc | clip;
`ifdef IIR_TAP_OUT_EN
            y_tap[int'(sec)*DW +: DW] <= rsat;
`endif
            // busy stays up through the cycle y_valid is shown
            if (last) begin
              y       <= rsat;
              y_valid <= 1'b1;
              sat     <= sat_acc | clip;
            end else begin
              sec <= sec + SW'(1);
            end
          end
          default: busy <= 1'b0;
        endcase
      end
    end
  end

  // Reset state is a passthrough: b0 = 1.0, everything else 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCO; i++)
        coef[i] <= (i % 5 == 0) ? CW'(2 ** FRAC) : '0;
    end else if (wr_ok) begin
      coef[coef_addr] <= coef_data;
    end
  end

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Directed checks for iir_biquad_cascade (NSEC=3, DW=21, CW=18, FRAC=14).
module tb_iir_biquad_cascade;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        en = 1'b0;
  logic [20:0] x = '0;
  logic [20:0] y;
  logic        y_valid;
  logic        busy;
  logic        sat;
  logic        overrun;
  logic        coef_we = 1'b0;
  logic [3:0]  coef_addr = '0;
  logic [17:0] coef_data = '0;
  logic        coef_err;

  iir_biquad_cascade dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .en        (en),
    .x         (x),
    .y         (y),
    .y_valid   (y_valid),
    .busy      (busy),
    .sat       (sat),
    .overrun   (overrun),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .coef_err  (coef_err)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input longint act,
                       input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model of the cascade
  longint mc [15];
  longint mx1 [3];
  longint mx2 [3];
  longint my1 [3];
  longint my2 [3];

  function automatic void m_coef_reset();
    for (int i = 0; i < 15; i++) mc[i] = (i % 5 == 0) ? 16384 : 0;
  endfunction

  function automatic void m_clr();
    for (int s = 0; s < 3; s++) begin
      mx1[s] = 0; mx2[s] = 0; my1[s] = 0; my2[s] = 0;
    end
  endfunction

  function automatic void m_step(input longint xi, output longint yo,
                                 output bit so);
    longint v, a, r;
    v = xi;
    so = 1'b0;
    for (int s = 0; s < 3; s++) begin
      a = mc[5*s] * v + mc[5*s+1] * mx1[s] + mc[5*s+2] * mx2[s]
        - mc[5*s+3] * my1[s] - mc[5*s+4] * my2[s];
      r = (a + 8192) >>> 14;
      if (r > 1048575) begin r = 1048575; so = 1'b1; end
      else if (r < -1048576) begin r = -1048576; so = 1'b1; end
      mx2[s] = mx1[s]; mx1[s] = v;
      my2[s] = my1[s]; my1[s] = r;
      v = r;
    end
    yo = v;
  endfunction

  bit busy_at_v;

  task automatic start(input longint xv);
    logic [20:0] xs;
    xs = xv[20:0];
    @(negedge clk);
    en = 1'b1;
    x = xs;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic wait_y(output longint yo, output bit so,
                        output int lat);
    lat = 0;
    yo = 0;
    so = 1'b0;
    forever begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (y_valid) break;
      if (lat > 100) begin
        check("y_valid_timeout", 0, 1);
        break;
      end
    end
    yo = longint'($signed(y));
    so = sat;
    busy_at_v = busy;
  endtask

  task automatic send(input longint xv, output longint yo,
                      output bit so, output int lat);
    start(xv);
    wait_y(yo, so, lat);
  endtask

  task automatic wr(input int a, input longint d, output bit err);
    logic [17:0] ds;
    ds = d[17:0];
    @(negedge clk);
    coef_we = 1'b1;
    coef_addr = 4'(a);
    coef_data = ds;
    @(posedge clk);
    @(negedge clk);
    coef_we = 1'b0;
    err = coef_err;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    m_clr();
  endtask

  typedef struct {
    longint x;
    longint y;
    bit     s;
  } vec_t;

  vec_t tbl [6];

  initial begin
    longint yo, ym, y_hold;
    bit     so, sm, err;
    int     lat, nv, at, e;

    tbl[0] = '{x: 1000,     y: 1000,     s: 1'b0};
    tbl[1] = '{x: -1,       y: -1,       s: 1'b0};
    tbl[2] = '{x: 0,        y: 0,        s: 1'b0};
    tbl[3] = '{x: 1048575,  y: 1048575,  s: 1'b0};
    tbl[4] = '{x: -1048576, y: -1048576, s: 1'b0};
    tbl[5] = '{x: 12345,    y: 12345,    s: 1'b0};

    m_coef_reset();
    m_clr();

    #23;
    check("rst_y", y, 0);
    check("rst_y_valid", y_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sat", sat, 0);
    check("rst_overrun", overrun, 0);
    check("rst_coef_err", coef_err, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      send(tbl[i].x, yo, so, lat);
      m_step(tbl[i].x, ym, sm);
      check($sformatf("pass_y[%0d]", i), yo, tbl[i].y);
      check($sformatf("pass_sat[%0d]", i), so, tbl[i].s);
      if (i == 0) begin
        check("latency", lat, 18);
        check("busy_with_valid", busy_at_v, 1);
        @(negedge clk);
        check("valid_falls", y_valid, 0);
        check("busy_falls", busy, 0);
      end
    end

    // Gain and one-sample memory in section 0
    do_clr();
    wr(0, 8192, err);
    check("wr_b0_err", err, 0);
    wr(1, 8192, err);
    check("wr_b1_err", err, 0);
    mc[0] = 8192;
    mc[1] = 8192;
    send(1000, yo, so, lat);
    m_step(1000, ym, sm);
    check("gain_y0", yo, 500);
    send(1000, yo, so, lat);
    m_step(1000, ym, sm);
    check("gain_y1", yo, 1000);

    // Out-of-range address is dropped
    wr(15, 0, err);
    check("addr15_err", err, 1);
    @(negedge clk);
    check("coef_err_pulse", coef_err, 0);
    send(2000, yo, so, lat);
    m_step(2000, ym, sm);
    check("addr15_model", yo, ym);
    check("addr15_hand", yo, 1500);

    // Write while busy is dropped
    start(4000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    coef_we = 1'b1;
    coef_addr = 4'd0;
    coef_data = '0;
    @(posedge clk);
    @(negedge clk);
    coef_we = 1'b0;
    check("busy_wr_err", coef_err, 1);
    wait_y(yo, so, lat);
    m_step(4000, ym, sm);
    check("busy_wr_model", yo, ym);

    // en and coef_we together: en wins
    @(negedge clk);
    en = 1'b1;
    x = 21'd600;
    coef_we = 1'b1;
    coef_addr = 4'd1;
    coef_data = '0;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    coef_we = 1'b0;
    check("en_wr_err", coef_err, 1);
    check("en_wr_busy", busy, 1);
    wait_y(yo, so, lat);
    m_step(600, ym, sm);
    check("en_wr_model", yo, ym);

    // Overrun: second en at E0+5 is dropped
    do_clr();
    check("clr_overrun0", overrun, 0);
    start(500);
    repeat (4) @(posedge clk);
    @(negedge clk);
    en = 1'b1;
    x = 21'd777;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    check("overrun_set", overrun, 1);
    nv = 0;
    at = 0;
    e = 5;
    yo = 0;
    repeat (30) begin
      @(posedge clk);
      e++;
      @(negedge clk);
      if (y_valid) begin
        nv++;
        at = e;
        yo = longint'($signed(y));
      end
    end
    m_step(500, ym, sm);
    check("overrun_nvalid", nv, 1);
    check("overrun_at", at, 18);
    check("overrun_y", yo, 250);
    check("overrun_sticky", overrun, 1);
    do_clr();
    check("overrun_cleared", overrun, 0);

    // Abort with clr at E0+7
    send(100, yo, so, lat);
    m_step(100, ym, sm);
    check("pre_abort_y", yo, ym);
    y_hold = longint'($signed(y));
    start(3000);
    repeat (6) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    m_clr();
    check("abort_busy", busy, 0);
    nv = 0;
    repeat (25) begin
      @(posedge clk);
      @(negedge clk);
      if (y_valid) nv++;
    end
    check("abort_no_valid", nv, 0);
    check("abort_y_held", longint'($signed(y)), y_hold);
    send(4000, yo, so, lat);
    m_step(4000, ym, sm);
    check("abort_fresh_model", yo, ym);
    check("abort_fresh_hand", yo, 2000);
    check("abort_fresh_lat", lat, 18);

    // Reset restores passthrough coefficients
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst2_y", y, 0);
    rst = 1'b1;
    m_coef_reset();
    m_clr();
    send(1000, yo, so, lat);
    m_step(1000, ym, sm);
    check("rst2_pass", yo, 1000);

    // Saturation with b0 = 2.0
    wr(0, 32768, err);
    check("wr_gain2_err", err, 0);
    mc[0] = 32768;
    send(1048575, yo, so, lat);
    m_step(1048575, ym, sm);
    check("sat_pos_y", yo, 1048575);
    check("sat_pos_flag", so, 1);
    send(-1048576, yo, so, lat);
    m_step(-1048576, ym, sm);
    check("sat_neg_y", yo, -1048576);
    check("sat_neg_flag", so, 1);
    send(100, yo, so, lat);
    m_step(100, ym, sm);
    check("nosat_y", yo, 200);
    check("nosat_flag", so, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
